// File: rtl/wb_pkg.sv
// Shared types for the write-back front end of the ID-stage register file.
package wb_pkg;

    localparam int DW = 16;
    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
    } md_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_MD
    } wb_src_e;

endpackage

// File: rtl/wb_md_fifo.sv
// Small synchronous FIFO buffering mul/div results until the write port is free.
module wb_md_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  md_entry_t                    din_i,
    output md_entry_t                    dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic [DEPTH-1:0][AW-1:0]     ent_wa_o,
    output logic [DEPTH-1:0]             ent_vld_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]              rd_q;
    logic [PW-1:0]              wr_q;
    logic [PW:0]                cnt_q;
    md_entry_t [DEPTH-1:0]      mem_q;
    logic [PW-1:0]              off;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        ent_vld_o = '0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = PW'(i) - rd_q;
            ent_vld_o[i] = {1'b0, off} < cnt_q;
            ent_wa_o[i]  = mem_q[i].wa;
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;

endmodule

// File: rtl/wb_regfile_writer.sv
// Merges ALU and buffered mul/div results onto the register-file write ports
// and reports pending-write hazards to decode.
module wb_regfile_writer
    import wb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_wa,
    input  logic [DW-1:0] alu_wd,
    input  logic          md_valid,
    output logic          md_ready,
    input  logic [AW-1:0] md_wa,
    input  logic [DW-1:0] md_lo,
    input  logic [DW-1:0] md_hi,
    output logic          wb_stall,
    input  logic [AW-1:0] qa1,
    input  logic [AW-1:0] qa2,
    output logic          hz1,
    output logic          hz2,
    output logic [AW-1:0] WA1,
    output logic [DW-1:0] WD1,
    output logic          RegWrite,
    output logic [DW-1:0] R0D,
    output logic          R0W
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_src_e                 src;
    md_entry_t               head;
    md_entry_t               din;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_cnt;
    logic [DEPTH-1:0][AW-1:0] ent_wa;
    logic [DEPTH-1:0]        ent_vld;
    logic                    push;
    logic                    pop;

    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          we_q, we_d;
    logic [DW-1:0] r0d_q, r0d_d;
    logic          r0w_q, r0w_d;
    logic          stall_q, stall_d;
    logic [SW-1:0] starve_q, starve_d;

    assign din      = '{wa: md_wa, lo: md_lo, hi: md_hi};
    assign md_ready = fifo_cnt != CW'(DEPTH);
    assign push     = md_valid && md_ready;
    assign pop      = src == SRC_MD;

    wb_md_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .pop_i     (pop),
        .din_i     (din),
        .dout_o    (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_cnt),
        .ent_wa_o  (ent_wa),
        .ent_vld_o (ent_vld)
    );

    always_comb begin
        src = SRC_NONE;
        priority case (1'b1)
            alu_valid:   src = SRC_ALU;
            !fifo_empty: src = SRC_MD;
            default:     src = SRC_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wa_q     <= '0;
            wd_q     <= '0;
            we_q     <= 1'b0;
            r0d_q    <= '0;
            r0w_q    <= 1'b0;
            stall_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            we_q     <= we_d;
            r0d_q    <= r0d_d;
            r0w_q    <= r0w_d;
            stall_q  <= stall_d;
            starve_q <= starve_d;
        end
    end

    // Idle cycles keep address/data so the port lines stay quiet.
    always_comb begin
        wa_d  = wa_q;
        wd_d  = wd_q;
        we_d  = 1'b0;
        r0d_d = r0d_q;
        r0w_d = 1'b0;
        case (src)
            SRC_ALU: begin
                we_d = 1'b1;
                wa_d = alu_wa;
                wd_d = alu_wd;
            end
            SRC_MD: begin
                r0w_d = 1'b1;
                r0d_d = head.hi;
                if (head.wa != '0) begin
                    we_d = 1'b1;
                    wa_d = head.wa;
                    wd_d = head.lo;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_d = '0;
        stall_d  = 1'b0;
        if (!fifo_empty && src == SRC_ALU) begin
            if (starve_q == SW'(STARVE_LIMIT - 1)) stall_d = 1'b1;
            else starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        hz1 = (!fifo_empty && qa1 == '0)
            || (we_q && wa_q == qa1)
            || (r0w_q && qa1 == '0);
        hz2 = (!fifo_empty && qa2 == '0)
            || (we_q && wa_q == qa2)
            || (r0w_q && qa2 == '0);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent_wa[i] == qa1) hz1 = 1'b1;
            if (ent_vld[i] && ent_wa[i] == qa2) hz2 = 1'b1;
        end
    end

    assign WA1      = wa_q;
    assign WD1      = wd_q;
    assign RegWrite = we_q;
    assign R0D      = r0d_q;
    assign R0W      = r0w_q;
    assign wb_stall = stall_q;

    always @(posedge clk) begin
        if (rst) begin
            assert (!(stall_q && alu_valid));
            assert (!(push && fifo_full));
        end
    end

endmodule

// File: doc/wb_regfile_writer.md
Name: wb_regfile_writer

Overview:
- Write-side front end of the ID-stage register file: generates the general write port (WA1/WD1/RegWrite) and the dedicated R0 port (R0D/R0W).
- Merges two result sources:
  - ALU results, single-cycle and non-stallable, one destination each.
  - Multi-cycle mul/div results: lo half to Rd, hi half to R0.
- Buffers mul/div results in a small FIFO and reports pending-write hazards to decode.

Parameters:
- DW, 16, data width of registers and results.
- AW, 4, register address width (16 registers).
- DEPTH, 2, mul/div result FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 3, consecutive cycles a FIFO head may be blocked by the ALU before a stall is requested.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU result valid this cycle
- alu_wa  in  AW  ALU destination register
- alu_wd  in  DW  ALU result
- md_valid  in  1  mul/div result offered
- md_ready  out  1  FIFO can accept (not full); combinational from FIFO count
- md_wa  in  AW  mul/div lo destination
- md_lo  in  DW  lo result (to md_wa)
- md_hi  in  DW  hi result (to R0)
- wb_stall  out  1  registered; upstream must hold alu_valid=0 in any cycle wb_stall=1
- qa1, qa2  in  AW  decode source addresses for hazard check
- hz1, hz2  out  1  combinational; pending write targets qa1/qa2
- WA1  out  AW  register-file write address
- WD1  out  DW  register-file write data
- RegWrite  out  1  general write enable
- R0D  out  DW  R0 write data
- R0W  out  1  R0 write enable

Behaviour:
- Reset, asynchronous and active-low:
  - FIFO emptied, starve counter = 0.
  - WA1=0, WD1=0, RegWrite=0, R0D=0, R0W=0, wb_stall=0.
  - Reset mid-operation discards buffered results; md_ready=1 after release.
- All write-port outputs are registered. Source presented in cycle N produces outputs in cycle N+1; the register file updates on the edge ending N+1.
- Port selection each cycle, evaluated in order:
  - alu_valid=1: WA1=alu_wa, WD1=alu_wd, RegWrite=1. FIFO head is blocked; R0W=0 (hi and lo of an entry are written atomically).
  - Else FIFO non-empty: pop head.
    - md_wa≠0: RegWrite=1, WA1=md_wa, WD1=lo, and R0W=1, R0D=hi, both in the same cycle.
    - md_wa=0: RegWrite=0, R0W=1, R0D=hi. lo is discarded; hi wins R0.
  - Else: RegWrite=0, R0W=0. WA1/WD1/R0D hold their previous values.
- FIFO push when md_valid && md_ready.
  - Push and pop in the same cycle are allowed, count unchanged.
  - Push into an empty FIFO is not popped in the same cycle: minimum mul/div latency is 2 cycles to RegWrite.
  - md_valid while full is ignored (no push). Upstream must hold its data.
- Starvation counter:
  - Increments each cycle with FIFO non-empty and alu_valid=1; clears on any pop or when the FIFO is empty.
  - When the count reaches STARVE_LIMIT, wb_stall=1 for exactly one cycle (next cycle) and the counter clears.
  - alu_valid=1 while wb_stall=1 is a protocol violation. The ALU still wins the port; an assertion flags it.
- Hazards:
  - hzK=1 if any FIFO entry has md_wa==qaK.
  - hzK=1 if qaK==0 and the FIFO is non-empty (hi targets R0).
  - hzK=1 if the output stage this cycle has RegWrite=1 with WA1==qaK, or R0W=1 with qaK==0.
  - An incoming same-cycle push is not included.
- R0 register through the general port (alu_wa=0) is legal. Program order between it and a buffered hi is decode's responsibility via hz.

Decomposition:
- Shared package wb_pkg holds:
  - DW, AW constants.
  - md_entry_t struct {wa, lo, hi}.
  - wb_src_e enum {SRC_NONE, SRC_ALU, SRC_MD}.
- One sub-module: wb_md_fifo, a parameterised synchronous FIFO.
  - Ports: push, pop, full, empty, count.
  - Exposes all entries for the hazard compare.
- Arbitration, starve counter, output registers and hazard logic stay in wb_regfile_writer.

Test Plan:
- Reset release, then alu_valid=1, alu_wa=5, alu_wd=16'h1234 at cycle 2 -> cycle 3: RegWrite=1, WA1=5, WD1=16'h1234, R0W=0. All outputs 0 during reset.
- md push wa=3, lo=16'h00F0, hi=16'hBEEF with no ALU traffic -> two cycles later: RegWrite=1, WA1=3, WD1=16'h00F0, and R0W=1, R0D=16'hBEEF in the same cycle. hz for qa1=3 is high until that cycle ends.
- md push wa=0, lo=16'h1111, hi=16'h2222 -> RegWrite=0, R0W=1, R0D=16'h2222. hz1=1 for qa1=0 while buffered.
- FIFO holds 2 entries, md_valid held high -> md_ready=0, no third push. One pop -> md_ready=1 the same cycle as the count drop.
- alu_valid=1 continuously with one md entry buffered -> after 3 blocked cycles wb_stall=1 for one cycle. Bench drops alu_valid; the entry writes the next cycle and the counter returns to 0.
- Assert rst low with 2 entries buffered and R0W=1 -> all outputs 0 immediately. After release, no stale writes; md_ready=1, hz1=hz2=0.
